// File: rtl/up3_control.sv
// up3 control unit: Moore sequencer for the two-byte fetch / decode / execute cycle.
// Strobes are decoded from the state register and the opcode latched in DECODE.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for run or a step pulse
// FETCH_U | read opcode byte into IR upper
// INC_U   | advance PC past opcode byte
// FETCH_L | read operand byte into IR lower
// INC_L   | advance PC past operand byte
// DECODE  | latch opcode; NOP/illegal retire here, HLT heads to HALT
// EXEC_A  | first execute cycle (LDA read, STA write, JMP/JZ load PC)
// EXEC_B  | LDA accumulator load
// HALT    | absorbing until reset
module up3_control (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_run,
   input  logic       i_step,
   input  logic [7:0] i_opcode,
   input  logic       i_ac_zero,
   output logic       o_fetch,
   output logic       o_store_mem,
   output logic       o_incr_pc,
   output logic       o_load_pc,
   output logic       o_load_iru,
   output logic       o_load_irl,
   output logic       o_load_ac,
   output logic       o_halted,
   output logic       o_illegal,
   output logic [3:0] o_state,
   output logic [7:0] o_instr_count
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH_U = 4'd1,
      S_INC_U   = 4'd2,
      S_FETCH_L = 4'd3,
      S_INC_L   = 4'd4,
      S_DECODE  = 4'd5,
      S_EXEC_A  = 4'd6,
      S_EXEC_B  = 4'd7,
      S_HALT    = 4'd8
   } state_t;

   localparam logic [7:0] OP_NOP = 8'h00;
   localparam logic [7:0] OP_LDA = 8'h01;
   localparam logic [7:0] OP_STA = 8'h02;
   localparam logic [7:0] OP_JMP = 8'h03;
   localparam logic [7:0] OP_JZ  = 8'h04;
   localparam logic [7:0] OP_HLT = 8'hFF;

   state_t     r_state;
   logic [7:0] r_op_q;
   logic [7:0] r_instr_count;
   logic       r_illegal;
   state_t     w_retire_state;

   // Dropping run mid-instruction only takes effect at the retire boundary.
   assign w_retire_state = i_run ? S_FETCH_U : S_IDLE;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state       <= S_IDLE;
         r_op_q        <= 8'h00;
         r_instr_count <= 8'h00;
         r_illegal     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_run || i_step)
                  r_state <= S_FETCH_U;
            end
            S_FETCH_U: r_state <= S_INC_U;
            S_INC_U:   r_state <= S_FETCH_L;
            S_FETCH_L: r_state <= S_INC_L;
            S_INC_L:   r_state <= S_DECODE;
            S_DECODE: begin
               r_op_q <= i_opcode;
               if (i_opcode == OP_HLT) begin
                  r_state       <= S_HALT;
                  r_instr_count <= r_instr_count + 8'd1;
               end else if ((i_opcode == OP_LDA) || (i_opcode == OP_STA) ||
                            (i_opcode == OP_JMP) || (i_opcode == OP_JZ)) begin
                  r_state <= S_EXEC_A;
               end else begin
                  r_state       <= w_retire_state;
                  r_instr_count <= r_instr_count + 8'd1;
                  if (i_opcode != OP_NOP)
                     r_illegal <= 1'b1;
               end
            end
            S_EXEC_A: begin
               if (r_op_q == OP_LDA) begin
                  r_state <= S_EXEC_B;
               end else begin
                  r_state       <= w_retire_state;
                  r_instr_count <= r_instr_count + 8'd1;
               end
            end
            S_EXEC_B: begin
               r_state       <= w_retire_state;
               r_instr_count <= r_instr_count + 8'd1;
            end
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      o_fetch     = 1'b0;
      o_store_mem = 1'b0;
      o_incr_pc   = 1'b0;
      o_load_pc   = 1'b0;
      o_load_iru  = 1'b0;
      o_load_irl  = 1'b0;
      o_load_ac   = 1'b0;
      case (r_state)
         S_FETCH_U: begin
            o_fetch    = 1'b1;
            o_load_iru = 1'b1;
         end
         S_INC_U:   o_incr_pc = 1'b1;
         S_FETCH_L: begin
            o_fetch    = 1'b1;
            o_load_irl = 1'b1;
         end
         S_INC_L:   o_incr_pc = 1'b1;
         S_EXEC_A: begin
            case (r_op_q)
               OP_LDA:  o_fetch     = 1'b1;
               OP_STA:  o_store_mem = 1'b1;
               OP_JMP:  o_load_pc   = 1'b1;
               OP_JZ:   o_load_pc   = i_ac_zero;
               default: ;
            endcase
         end
         S_EXEC_B:  o_load_ac = 1'b1;
         default:   ;
      endcase
   end

   assign o_halted      = (r_state == S_HALT);
   assign o_illegal     = r_illegal;
   assign o_state       = r_state;
   assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_up3_control.sv
// Directed bench for up3_control: reset, single-step, free-run, JZ, illegal, wrap and HLT.
module tb_up3_control;

   logic       clk;
   logic       reset;
   logic       run;
   logic       step;
   logic [7:0] opcode;
   logic       ac_zero;
   logic       fetch, store_mem, incr_pc, load_pc, load_iru, load_irl, load_ac;
   logic       halted, illegal;
   logic [3:0] state;
   logic [7:0] instr_count;
   logic [6:0] sb;

   int n_cmp = 0;
   int n_err = 0;

   up3_control dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_run         (run),
      .i_step        (step),
      .i_opcode      (opcode),
      .i_ac_zero     (ac_zero),
      .o_fetch       (fetch),
      .o_store_mem   (store_mem),
      .o_incr_pc     (incr_pc),
      .o_load_pc     (load_pc),
      .o_load_iru    (load_iru),
      .o_load_irl    (load_irl),
      .o_load_ac     (load_ac),
      .o_halted      (halted),
      .o_illegal     (illegal),
      .o_state       (state),
      .o_instr_count (instr_count)
   );

   // {fetch, store_mem, incr_pc, load_pc, load_iru, load_irl, load_ac}
   assign sb = {fetch, store_mem, incr_pc, load_pc, load_iru, load_irl, load_ac};

   localparam logic [6:0] SB_NONE = 7'b0000000;
   localparam logic [6:0] SB_FU   = 7'b1000100;
   localparam logic [6:0] SB_INC  = 7'b0010000;
   localparam logic [6:0] SB_FL   = 7'b1000010;
   localparam logic [6:0] SB_RD   = 7'b1000000;
   localparam logic [6:0] SB_WR   = 7'b0100000;
   localparam logic [6:0] SB_LPC  = 7'b0001000;
   localparam logic [6:0] SB_LAC  = 7'b0000001;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one step from IDLE; return cycles spent outside IDLE/HALT and strobes seen in EXEC_A.
   task automatic run_step(input logic [7:0] op, input logic az,
                           output int len, output logic [6:0] ex_sb);
      opcode  = op;
      ac_zero = az;
      step    = 1'b1;
      tick();
      step  = 1'b0;
      len   = 0;
      ex_sb = SB_NONE;
      while (len < 30 && state != 4'd0 && state != 4'd8) begin
         if (state == 4'd6)
            ex_sb = sb;
         len++;
         tick();
      end
   endtask

   logic [3:0] exp_st [13] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                               4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
   logic [6:0] exp_sb [13] = '{SB_FU, SB_INC, SB_FL, SB_INC, SB_NONE, SB_RD, SB_LAC,
                               SB_FU, SB_INC, SB_FL, SB_INC, SB_NONE, SB_WR};

   initial begin
      int         len;
      int         cyc;
      logic [6:0] ex;
      logic       saw_idle;

      reset   = 1'b0;
      run     = 1'b0;
      step    = 1'b0;
      opcode  = 8'h00;
      ac_zero = 1'b0;
      tick();
      tick();
      chk("rst_state", state, 4'd0);
      chk("rst_strobes", sb, SB_NONE);
      chk("rst_count", instr_count, 8'h00);
      chk("rst_halted", halted, 1'b0);
      chk("rst_illegal", illegal, 1'b0);
      reset = 1'b1;
      tick();
      tick();
      chk("idle_hold", state, 4'd0);

      // Single-step NOP, with a stray step during INC_U
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("ss_st1", state, 4'd1);
      chk("ss_sb1", sb, SB_FU);
      tick();
      chk("ss_st2", state, 4'd2);
      chk("ss_sb2", sb, SB_INC);
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("ss_st3", state, 4'd3);
      chk("ss_sb3", sb, SB_FL);
      tick();
      chk("ss_st4", state, 4'd4);
      chk("ss_sb4", sb, SB_INC);
      tick();
      chk("ss_st5", state, 4'd5);
      chk("ss_sb5", sb, SB_NONE);
      tick();
      chk("ss_st0", state, 4'd0);
      chk("ss_count", instr_count, 8'h01);
      tick();
      tick();
      chk("ss_no_queue", state, 4'd0);

      // Async reset while in FETCH_L
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      tick();
      chk("mid_fl_state", state, 4'd3);
      reset = 1'b0;
      #1;
      chk("async_strobes", sb, SB_NONE);
      chk("async_state", state, 4'd0);
      chk("async_count", instr_count, 8'h00);
      tick();
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("post_rst_idle", state, 4'd0);
      end

      // Free-run LDA then STA, run dropped in STA EXEC_A
      opcode = 8'h01;
      run    = 1'b1;
      for (int i = 0; i < 13; i++) begin
         tick();
         chk($sformatf("fr_st%0d", i), state, exp_st[i]);
         chk($sformatf("fr_sb%0d", i), sb, exp_sb[i]);
         if (i == 5)
            opcode = 8'h02;
         if (i == 12)
            run = 1'b0;
      end
      tick();
      chk("fr_end_state", state, 4'd0);
      chk("fr_count", instr_count, 8'h02);

      // JZ taken and not taken
      run_step(8'h04, 1'b1, len, ex);
      chk("jz1_len", len, 6);
      chk("jz1_exec_sb", ex, SB_LPC);
      run_step(8'h04, 1'b0, len, ex);
      chk("jz0_len", len, 6);
      chk("jz0_exec_sb", ex, SB_NONE);
      chk("jz_count", instr_count, 8'h04);

      // JMP and illegal opcode
      run_step(8'h03, 1'b0, len, ex);
      chk("jmp_len", len, 6);
      chk("jmp_exec_sb", ex, SB_LPC);
      chk("pre_ill", illegal, 1'b0);
      run_step(8'h7E, 1'b0, len, ex);
      chk("ill_len", len, 5);
      chk("ill_flag", illegal, 1'b1);
      run_step(8'h00, 1'b0, len, ex);
      chk("ill_sticky", illegal, 1'b1);
      chk("ill_count", instr_count, 8'h07);

      // Counter wrap over 256 free-running NOPs
      reset = 1'b0;
      #1;
      chk("wrap_rst_ill", illegal, 1'b0);
      tick();
      reset    = 1'b1;
      opcode   = 8'h00;
      run      = 1'b1;
      cyc      = 0;
      saw_idle = 1'b0;
      while (cyc < 2000) begin
         tick();
         cyc++;
         if (state == 4'd0)
            saw_idle = 1'b1;
         if (state == 4'd5 && instr_count == 8'hFF)
            break;
      end
      chk("wrap_cycles", cyc, 1280);
      chk("wrap_no_idle", saw_idle, 1'b0);
      run = 1'b0;
      tick();
      chk("wrap_idle", state, 4'd0);
      chk("wrap_count", instr_count, 8'h00);

      // HLT is absorbing
      run_step(8'hFF, 1'b0, len, ex);
      chk("hlt_len", len, 5);
      chk("hlt_state", state, 4'd8);
      chk("hlt_halted", halted, 1'b1);
      chk("hlt_count", instr_count, 8'h01);
      run = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step = i[0];
         tick();
         chk("hlt_hold", state, 4'd8);
      end
      chk("hlt_hold_sb", sb, SB_NONE);
      step  = 1'b0;
      run   = 1'b0;
      reset = 1'b0;
      #1;
      chk("hlt_rst_halted", halted, 1'b0);
      chk("hlt_rst_state", state, 4'd0);
      tick();
      reset = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
